uart_tx_fifo: RTL and testbench

Byte FIFO with transmit-side flow control that sits between `uart_receive` and `uart_transmit` in the echo path. It captures every byte strobed out of the receiver, buffers up to DEPTH bytes, and issues one-cycle `send` strobes to the transmitter only when the transmitter reports idle. Bursts arriving faster than the transmitter can drain them are no longer lost.

---
 rtl/uart_tx_fifo.sv | 92 +++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between receiver and transmitter, one send strobe per transmitter busy period
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   tx_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_send,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             pend_q, pend_d;
    logic             out_send_q, out_send_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;

    assign empty    = count_q == '0;
    assign full     = count_q == CW'(DEPTH);
    assign push     = in_valid && !full;
    assign pop      = state_q == IDLE && !empty && tx_ready;
    assign count    = count_q;
    assign out_data = out_data_q;
    assign out_send = out_send_q;
    assign overflow = overflow_q;

    // Storage, pointers and count; the popped byte is latched now and strobed one cycle later
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = in_data;
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        out_data_d = pop ? mem_q[rptr_q] : out_data_q;
        pend_d     = pop;
        out_send_d = pend_q;
        overflow_d = in_valid && full;
    end

    // Handshake FSM: after a pop, wait for the transmitter to go busy and then idle again
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = pop ? WAIT_BUSY : IDLE;
            WAIT_BUSY: state_d = tx_ready ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: state_d = tx_ready ? IDLE : WAIT_DONE;
            default:   state_d = IDLE;
        endcase
    end

    // State registers; reset drops all buffered bytes and any pending strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            pend_q     <= 1'b0;
            out_send_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            pend_q     <= pend_d;
            out_send_q <= out_send_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed tests against a queue-based model of the FIFO and transmitter handshake
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    typedef logic [7:0] byte_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        tx_hold = 1'b0;
    logic        tx_ready;
    logic [7:0]  out_data;
    logic        out_send;
    logic [4:0]  count;
    logic        empty, full, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy = 0;
    int busy_len = 10;
    int send_cyc = -1;
    int pc, base;

    byte_t q[$];
    byte_t sent[$];
    byte_t exp_data = '0;
    logic  exp_send = 1'b0, stage = 1'b0, exp_ovf = 1'b0;
    logic  armed = 1'b1, low_seen = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .tx_ready(tx_ready),
        .out_data(out_data), .out_send(out_send), .count(count), .empty(empty), .full(full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign tx_ready = !tx_hold && busy == 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sent_at(input int i);
        return (i < sent.size()) ? 32'(sent[i]) : 32'hDEAD_BEEF;
    endfunction

    // Transmitter: accepts a send while idle, then stays busy for busy_len cycles
    always @(negedge clk) begin
        if (busy > 0) busy--;
        else if (out_send && tx_ready) busy = busy_len;
        if (out_send) begin
            sent.push_back(out_data);
            send_cyc = cyc;
        end
    end

    // Reference model: a byte queue plus the one-send-per-busy-period rule
    always @(posedge clk) begin
        int n;
        logic p;
        cyc++;
        if (!reset) begin
            q.delete();
            exp_data = '0; exp_send = 0; stage = 0; exp_ovf = 0; armed = 1; low_seen = 0;
        end else begin
            n = q.size();
            p = armed && n > 0 && tx_ready;
            exp_send = stage;
            stage = p;
            exp_ovf = in_valid && n == DEPTH;
            if (p) begin
                exp_data = q.pop_front();
                armed = 0;
                low_seen = 0;
            end else if (!armed) begin
                if (!low_seen) begin
                    if (!tx_ready) low_seen = 1;
                end else if (tx_ready) armed = 1;
            end
            if (in_valid && n < DEPTH) q.push_back(in_data);
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        check("cmp_count", count, q.size());
        check("cmp_empty", empty, q.size() == 0);
        check("cmp_full", full, q.size() == DEPTH);
        check("cmp_overflow", overflow, exp_ovf);
        check("cmp_send", out_send, exp_send);
        check("cmp_data", out_data, exp_data);
    end

    task automatic check_reset(input string tag);
        check({tag, "_send"}, out_send, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic push1(input byte_t b, output int at);
        @(negedge clk);
        in_valid = 1; in_data = b;
        @(negedge clk);
        in_valid = 0;
        at = cyc;
    endtask

    task automatic push_run(input byte_t b0, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1; in_data = b0 + byte_t'(i);
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_sent(input int n, input int lim);
        int k = 0;
        while (sent.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("wait_sent", sent.size(), n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("rst0");
        reset = 1;

        // Single byte: 2-cycle latency, one send per busy period
        busy_len = 10;
        push1(8'h41, pc);
        wait_sent(1, 20);
        check("t1_latency", send_cyc - pc, 2);
        check("t1_data", sent_at(0), 8'h41);
        repeat (20) @(negedge clk);
        check("t1_single", sent.size(), 1);

        // Five bytes queued while the transmitter is held busy
        tx_hold = 1;
        push_run(8'h01, 5);
        check("t2_count", count, 5);
        check("t2_nosend", sent.size(), 1);
        tx_hold = 0;
        wait_sent(6, 400);
        for (int i = 0; i < 5; i++) check("t2_order", sent_at(1 + i), 1 + i);

        // Fill to DEPTH, then an extra byte overflows
        repeat (15) @(negedge clk);
        tx_hold = 1;
        push_run(8'h10, 16);
        check("t3_count", count, 16);
        check("t3_full", full, 1);
        push1(8'hFF, pc);
        check("t3_ovf", overflow, 1);
        check("t3_count_hold", count, 16);
        @(negedge clk);
        check("t3_ovf_pulse", overflow, 0);

        // Push coinciding with pop at count 16: push dropped
        tx_hold = 0; in_valid = 1; in_data = 8'hEE;
        @(negedge clk);
        in_valid = 0;
        check("t4f_count", count, 15);
        check("t4f_ovf", overflow, 1);
        wait_sent(22, 1000);
        for (int i = 0; i < 16; i++) check("t3_order", sent_at(6 + i), 8'h10 + i);

        // Push coinciding with pop at count 3
        repeat (15) @(negedge clk);
        tx_hold = 1;
        push_run(8'h31, 3);
        check("t4_count", count, 3);
        tx_hold = 0; in_valid = 1; in_data = 8'h34;
        @(negedge clk);
        in_valid = 0;
        check("t4_count_same", count, 3);
        wait_sent(26, 400);
        for (int i = 0; i < 4; i++) check("t4_order", sent_at(22 + i), 8'h31 + i);

        // 40-byte stream against a 10-bit frame at divider 8
        busy_len = 80;
        base = sent.size();
        begin
            int idx = 0, k = 0;
            while (idx < 40 && k < 5000) begin
                @(negedge clk);
                k++;
                if (q.size() < DEPTH) begin
                    in_valid = 1; in_data = byte_t'(idx * 7 + 3); idx++;
                end else in_valid = 0;
            end
            @(negedge clk);
            in_valid = 0;
            check("t5_pushed", idx, 40);
        end
        wait_sent(base + 40, 5000);
        for (int i = 0; i < 40; i++) check("t5_stream", sent_at(base + i), (i * 7 + 3) & 8'hFF);

        // Reset in the middle of a burst
        repeat (90) @(negedge clk);
        base = sent.size();
        push_run(8'h50, 8);
        check("t6_count", count, 7);
        #1 reset = 0;
        #1 check_reset("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1;
        begin
            int k = 0;
            while (!tx_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("t6_tx_idle", tx_ready, 1);
        end
        push1(8'hA5, pc);
        wait_sent(base + 2, 20);
        check("t6_first", sent_at(base), 8'h50);
        check("t6_latency", send_cyc - pc, 2);
        check("t6_data", sent_at(base + 1), 8'hA5);
        repeat (100) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
